// File: rtl/cu_definitions_pkg.sv
// Shared definitions for the control-unit decoders.
// Contents:
//   - inst_header : 10-bit instruction header {op[9:8], imm[7], cmd[6:3], rsvd[2:0]}
//   - op_e        : instruction class (PROCESSING / MEMORY / BRANCH / VECTOR)
//   - *_cmd_e     : per-class command encodings
//   - ALU_*       : ALUCtrl encodings
//   - ctrl_t      : deco_exe control bundle (CTRL_W bits)
//   - decode_t    : full decode result incl. register-source selects and flags
//   - decode_header() : pure header -> decode_t mapping
package cu_definitions_pkg;

  localparam int unsigned HDR_W  = 10;
  localparam int unsigned CTRL_W = 10;

  typedef enum logic [1:0] {
    OP_PROCESSING = 2'b00,
    OP_MEMORY     = 2'b01,
    OP_BRANCH     = 2'b10,
    OP_VECTOR     = 2'b11
  } op_e;

  // Shared by PROCESSING and VECTOR classes
  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_AND = 4'd1,
    CMD_XOR = 4'd2,
    CMD_SUB = 4'd3,
    CMD_ADD = 4'd4,
    CMD_CMP = 4'd5
  } alu_cmd_e;

  typedef enum logic [3:0] {
    CMD_LDR = 4'd0,
    CMD_STR = 4'd1
  } mem_cmd_e;

  typedef enum logic [3:0] {
    CMD_B  = 4'd0,
    CMD_BL = 4'd1
  } br_cmd_e;

  typedef struct packed {
    op_e        op;
    logic       imm;
    logic [3:0] cmd;
    logic [2:0] rsvd;
  } inst_header;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic [2:0] alu_ctrl;
    logic       flags_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       vec_mode;
  } ctrl_t;

  typedef struct packed {
    ctrl_t bundle;
    logic  reg_src_a1;
    logic  reg_src_a2;
    logic  b_link;
    logic  illegal;
    logic  is_vector;
  } decode_t;

  // Undefined encodings collapse to an all-zero single-beat bundle with
  // only the illegal flag set; rsvd bits never influence the result.
  function automatic decode_t decode_header(inst_header h);
    decode_t d;
    d = '0;
    case (h.op)
      OP_PROCESSING, OP_VECTOR: begin
        d.bundle.alu_src  = h.imm;
        d.bundle.vec_mode = (h.op == OP_VECTOR);
        d.is_vector       = (h.op == OP_VECTOR);
        case (h.cmd)
          CMD_NOP: ;
          CMD_AND: begin d.bundle.reg_write = 1'b1; d.bundle.alu_ctrl = ALU_AND; end
          CMD_XOR: begin d.bundle.reg_write = 1'b1; d.bundle.alu_ctrl = ALU_XOR; end
          CMD_SUB: begin d.bundle.reg_write = 1'b1; d.bundle.alu_ctrl = ALU_SUB; end
          CMD_ADD: begin d.bundle.reg_write = 1'b1; d.bundle.alu_ctrl = ALU_ADD; end
          CMD_CMP: begin d.bundle.flags_write = 1'b1; d.bundle.alu_ctrl = ALU_SUB; end
          default: d.illegal = 1'b1;
        endcase
      end
      OP_MEMORY: begin
        d.bundle.alu_src  = 1'b1;
        d.bundle.alu_ctrl = ALU_ADD;
        case (h.cmd)
          CMD_LDR: begin d.bundle.reg_write = 1'b1; d.bundle.mem_to_reg = 1'b1; end
          CMD_STR: begin d.bundle.mem_write = 1'b1; d.reg_src_a2 = 1'b1; end
          default: d.illegal = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        d.bundle.alu_src  = 1'b1;
        d.bundle.alu_ctrl = ALU_ADD;
        d.bundle.branch   = 1'b1;
        d.reg_src_a1      = 1'b1;
        case (h.cmd)
          CMD_B:  ;
          CMD_BL: begin d.b_link = 1'b1; d.bundle.reg_write = 1'b1; end
          default: d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    if (d.illegal) begin
      d         = '0;
      d.illegal = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/cu_beat_counter.sv
// Beat counter for multi-beat instruction sequencing.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clr        : return count to 0 (dominates i_inc)
//   i_inc        : advance count by one
//   i_term       : terminal (last) beat index of the current instruction
//   o_count      : current beat index
//   o_at_term    : o_count equals i_term
module cu_beat_counter #(
  parameter int unsigned BW = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_inc,
  input  logic [BW-1:0] i_term,
  output logic [BW-1:0] o_count,
  output logic          o_at_term
);

  logic [BW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + BW'(1);
    end
  end

  assign o_count   = r_count;
  assign o_at_term = (r_count == i_term);

endmodule

// File: rtl/cu_seq_decoder.sv
// Registered multi-beat control unit between fetch/decode and decode/execute.
// Decodes the instruction header into the deco_exe control bundle and
// sequences vector instructions over VLEN/LANES beats with valid/ready
// handshakes on both sides.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : header handshake (upstream)
//   inst_head            : {op[9:8], imm[7], cmd[6:3], rsvd[2:0]}
//   flush                : drop current instruction, refuse new header this cycle
//   out_valid / out_ready: beat handshake (downstream)
//   ctr_signal           : {RegWrite, ALUSrc, ALUCtrl[2:0], FlagsWrite,
//                           MemWrite, MemToReg, Branch, VecMode}
//   RegSrcA1/RegSrcA2/bLink : register-file source selects, link write
//   beat_idx / last_beat : current beat and final-beat flag
//   illegal              : undefined encoding (NOP bundle emitted)
module cu_seq_decoder
  import cu_definitions_pkg::*;
#(
  parameter  int unsigned VLEN     = 16,
  parameter  int unsigned LANES    = 4,
  parameter  int unsigned HEADER_W = 10,
  localparam int unsigned BEATS    = VLEN / LANES,
  localparam int unsigned BW       = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [HEADER_W-1:0] inst_head,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CTRL_W-1:0]   ctr_signal,
  output logic                RegSrcA1,
  output logic                RegSrcA2,
  output logic                bLink,
  output logic [BW-1:0]       beat_idx,
  output logic                last_beat,
  output logic                illegal
);

  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } state_e;

  localparam logic [BW-1:0] LAST_VEC = BW'(BEATS - 1);

  state_e        r_state;
  state_e        w_state_nxt;
  decode_t       r_dec;
  decode_t       w_dec;
  logic          w_load;
  logic          w_cnt_clr;
  logic          w_cnt_inc;
  logic          w_at_term;
  logic          w_valid;
  logic [BW-1:0] w_beat;
  logic [BW-1:0] w_term;

  assign w_dec   = decode_header(inst_header'(inst_head));
  assign w_valid = (r_state == ST_ISSUE);
  assign w_term  = r_dec.is_vector ? LAST_VEC : '0;

  cu_beat_counter #(
    .BW (BW)
  ) u_beat_counter (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_clr     (w_cnt_clr),
    .i_inc     (w_cnt_inc),
    .i_term    (w_term),
    .o_count   (w_beat),
    .o_at_term (w_at_term)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Decoded instruction is captured at acceptance and held for all beats
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dec <= '0;
    end else if (w_load) begin
      r_dec <= w_dec;
    end
  end

  // Next-state / sequencing. Acceptance in ISSUE is only possible on the
  // last-beat handshake, which gives back-to-back issue without a bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    if (flush) begin
      w_state_nxt = ST_IDLE;
      w_cnt_clr   = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            w_load      = 1'b1;
            w_cnt_clr   = 1'b1;
            w_state_nxt = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (out_ready) begin
            if (!w_at_term) begin
              w_cnt_inc = 1'b1;
            end else begin
              w_cnt_clr = 1'b1;
              if (in_valid) begin
                w_load = 1'b1;
              end else begin
                w_state_nxt = ST_IDLE;
              end
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are gated by out_valid so IDLE (after reset or flush) presents
  // an all-zero bundle without clearing the held decode.
  always_comb begin
    out_valid  = w_valid;
    in_ready   = !rst && !flush &&
                 ((r_state == ST_IDLE) || (w_valid && out_ready && w_at_term));
    ctr_signal = w_valid ? r_dec.bundle : '0;
    RegSrcA1   = w_valid && r_dec.reg_src_a1;
    RegSrcA2   = w_valid && r_dec.reg_src_a2;
    bLink      = w_valid && r_dec.b_link;
    illegal    = w_valid && r_dec.illegal;
    beat_idx   = w_valid ? w_beat : '0;
    last_beat  = w_valid && w_at_term;
  end

endmodule

// File: tb/tb_cu_seq_decoder.sv
module tb_cu_seq_decoder;

  localparam int unsigned VLEN  = 16;
  localparam int unsigned LANES = 4;
  localparam int unsigned BEATS = VLEN / LANES;
  localparam int unsigned BW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [9:0]    inst_head;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [9:0]    ctr_signal;
  logic          RegSrcA1;
  logic          RegSrcA2;
  logic          bLink;
  logic [BW-1:0] beat_idx;
  logic          last_beat;
  logic          illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cu_seq_decoder #(
    .VLEN     (VLEN),
    .LANES    (LANES),
    .HEADER_W (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .inst_head  (inst_head),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ctr_signal (ctr_signal),
    .RegSrcA1   (RegSrcA1),
    .RegSrcA2   (RegSrcA2),
    .bLink      (bLink),
    .beat_idx   (beat_idx),
    .last_beat  (last_beat),
    .illegal    (illegal)
  );

  typedef struct {
    logic [1:0] op;
    logic       imm;
    logic [3:0] cmd;
    logic [9:0] ctrl;
    logic       a1;
    logic       a2;
    logic       bl;
    logic       ill;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] hdr(input logic [1:0] op, input logic imm, input logic [3:0] cmd,
                                     input logic [2:0] rsvd);
    return {op, imm, cmd, rsvd};
  endfunction

  // Reference decode from the instruction-set rules.
  // Returns {ctrl[9:0], a1, a2, bl, ill, vector}.
  function automatic logic [14:0] ref_decode(input logic [1:0] op, input logic imm, input logic [3:0] cmd);
    logic rw, src, fw, mw, m2r, br, vm, a1, a2, bl, ill, vec;
    logic [2:0] alu;
    {rw, src, fw, mw, m2r, br, vm, a1, a2, bl, ill, vec} = '0;
    alu = 3'b000;
    if (op == 2'b00 || op == 2'b11) begin
      if (cmd > 4'd5) ill = 1'b1;
      else begin
        src = imm;
        vec = (op == 2'b11);
        vm  = vec;
        rw  = (cmd >= 4'd1) && (cmd <= 4'd4);
        fw  = (cmd == 4'd5);
        if (cmd == 4'd1) alu = 3'b010;
        else if (cmd == 4'd2) alu = 3'b011;
        else if (cmd == 4'd3 || cmd == 4'd5) alu = 3'b001;
      end
    end else if (cmd > 4'd1) begin
      ill = 1'b1;
    end else if (op == 2'b01) begin
      src = 1'b1;
      if (cmd == 4'd0) begin rw = 1'b1; m2r = 1'b1; end
      else begin mw = 1'b1; a2 = 1'b1; end
    end else begin
      src = 1'b1; br = 1'b1; a1 = 1'b1;
      if (cmd == 4'd1) begin bl = 1'b1; rw = 1'b1; end
    end
    return {rw, src, alu, fw, mw, m2r, br, vm, a1, a2, bl, ill, vec};
  endfunction

  // Random-phase model state
  logic        m_busy;
  int          m_beat;
  int          m_beats;
  logic [14:0] m_dec;

  initial begin
    logic [18:0] act, exp;
    logic        m_last, exp_rdy;
    logic [9:0]  h;

    tbl[0]  = '{2'b00, 1'b0, 4'd4,  10'h200, 0, 0, 0, 0}; // ADD reg
    tbl[1]  = '{2'b00, 1'b1, 4'd4,  10'h300, 0, 0, 0, 0}; // ADD imm
    tbl[2]  = '{2'b10, 1'b0, 4'd1,  10'h302, 1, 0, 1, 0}; // BL
    tbl[3]  = '{2'b00, 1'b0, 4'd5,  10'h030, 0, 0, 0, 0}; // CMP
    tbl[4]  = '{2'b01, 1'b0, 4'd0,  10'h304, 0, 0, 0, 0}; // LDR
    tbl[5]  = '{2'b01, 1'b1, 4'd1,  10'h108, 0, 1, 0, 0}; // STR
    tbl[6]  = '{2'b10, 1'b1, 4'd0,  10'h102, 1, 0, 0, 0}; // B
    tbl[7]  = '{2'b00, 1'b1, 4'd1,  10'h340, 0, 0, 0, 0}; // AND imm
    tbl[8]  = '{2'b00, 1'b0, 4'd2,  10'h260, 0, 0, 0, 0}; // XOR
    tbl[9]  = '{2'b00, 1'b0, 4'd3,  10'h220, 0, 0, 0, 0}; // SUB
    tbl[10] = '{2'b00, 1'b0, 4'd9,  10'h000, 0, 0, 0, 1}; // undefined processing
    tbl[11] = '{2'b01, 1'b1, 4'd7,  10'h000, 0, 0, 0, 1}; // undefined memory
    tbl[12] = '{2'b10, 1'b0, 4'd15, 10'h000, 0, 0, 0, 1}; // undefined branch
    tbl[13] = '{2'b11, 1'b0, 4'd12, 10'h000, 0, 0, 0, 1}; // undefined vector: single beat

    rst = 1'b1; in_valid = 1'b0; inst_head = '0; flush = 1'b0; out_ready = 1'b0;

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_outputs", 32'({ctr_signal, RegSrcA1, RegSrcA2, bLink, illegal, last_beat, beat_idx}), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Single-instruction table
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      inst_head = hdr(tbl[i].op, tbl[i].imm, tbl[i].cmd, 3'(i));
      #1;
      chk($sformatf("t%0d_in_ready", i), 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      #1;
      chk($sformatf("t%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("t%0d_ctrl", i), 32'(ctr_signal), 32'(tbl[i].ctrl));
      chk($sformatf("t%0d_flags", i), 32'({RegSrcA1, RegSrcA2, bLink, illegal}),
          32'({tbl[i].a1, tbl[i].a2, tbl[i].bl, tbl[i].ill}));
      chk($sformatf("t%0d_last", i), 32'({last_beat, beat_idx}), 32'({1'b1, 2'd0}));
      tick();
      chk($sformatf("t%0d_idle", i), 32'({out_valid, illegal}), 32'd0);
    end

    // Vector ADD with STR queued behind it
    in_valid = 1'b1; out_ready = 1'b1; inst_head = hdr(2'b11, 1'b0, 4'd4, 3'd0);
    tick();
    inst_head = hdr(2'b01, 1'b0, 4'd1, 3'd0);
    for (int b = 0; b < 4; b++) begin
      #1;
      chk($sformatf("vadd_b%0d_idx", b), 32'(beat_idx), 32'(b));
      chk($sformatf("vadd_b%0d_ctrl", b), 32'({out_valid, ctr_signal}), 32'({1'b1, 10'h201}));
      chk($sformatf("vadd_b%0d_rdy_last", b), 32'({in_ready, last_beat}), (b == 3) ? 32'h3 : 32'h0);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("str_b2b", 32'({out_valid, ctr_signal, RegSrcA2, last_beat}), 32'({1'b1, 10'h108, 1'b1, 1'b1}));
    tick();
    chk("str_done", 32'(out_valid), 32'd0);

    // Vector SUB with backpressure at beat 1
    in_valid = 1'b1; inst_head = hdr(2'b11, 1'b0, 4'd3, 3'd0);
    tick();
    in_valid = 1'b0;
    #1; chk("vsub_b0", 32'(beat_idx), 32'd0);
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("vsub_hold%0d", k), 32'({out_valid, in_ready, beat_idx, ctr_signal}),
          32'({1'b1, 1'b0, 2'd1, 10'h221}));
      tick();
    end
    out_ready = 1'b1;
    #1; chk("vsub_resume_b1", 32'(beat_idx), 32'd1);
    tick();
    chk("vsub_b2", 32'(beat_idx), 32'd2);
    tick();
    chk("vsub_b3", 32'({beat_idx, last_beat}), 32'({2'd3, 1'b1}));
    tick();
    chk("vsub_done", 32'(out_valid), 32'd0);

    // Flush at beat 2, then an undefined header
    in_valid = 1'b1; inst_head = hdr(2'b11, 1'b1, 4'd4, 3'd0);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    flush = 1'b1; in_valid = 1'b1; inst_head = hdr(2'b00, 1'b0, 4'd9, 3'd0);
    #1;
    chk("flush_beat", 32'(beat_idx), 32'd2);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("post_flush", 32'({out_valid, beat_idx, illegal, in_ready}), 32'({1'b0, 2'd0, 1'b0, 1'b1}));
    tick();
    in_valid = 1'b0;
    #1;
    chk("illegal_beat", 32'({out_valid, illegal, last_beat, ctr_signal}), 32'({1'b1, 1'b1, 1'b1, 10'h000}));
    tick();
    chk("illegal_cleared", 32'({out_valid, illegal}), 32'd0);

    // Flush coinciding with last-beat handshake: next header refused
    in_valid = 1'b1; inst_head = hdr(2'b00, 1'b0, 4'd4, 3'd0);
    tick();
    flush = 1'b1;
    #1; chk("flush_last_rdy", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1; chk("flush_last_idle", 32'(out_valid), 32'd0);

    // Reset mid-vector
    in_valid = 1'b1; inst_head = hdr(2'b11, 1'b0, 4'd1, 3'd0);
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_vec", 32'({out_valid, beat_idx, in_ready}), 32'd0);
    rst = 1'b0;
    #1; chk("rst_mid_rdy", 32'(in_ready), 32'd1);

    // Randomized traffic against the transaction model
    m_busy = 1'b0; m_beat = 0; m_beats = 1; m_dec = '0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      h = 10'($urandom);
      if ($urandom_range(0, 3) != 0) h[6:3] = 4'($urandom_range(0, 5));
      inst_head = h;
      #1;
      m_last  = m_busy && (m_beat == m_beats - 1);
      exp_rdy = !rst && !flush && (!m_busy || (m_last && out_ready));
      exp = {m_busy, exp_rdy, m_last, m_busy ? 2'(m_beat) : 2'd0,
             m_busy ? m_dec[4:1] : 4'd0, m_busy ? m_dec[14:5] : 10'd0};
      act = {out_valid, in_ready, last_beat, beat_idx, RegSrcA1, RegSrcA2, bLink, illegal, ctr_signal};
      chk($sformatf("rand_c%0d", c), 32'(act), 32'(exp));
      if (rst || flush) begin
        m_busy = 1'b0; m_beat = 0;
      end else if (m_busy && out_ready && !m_last) begin
        m_beat++;
      end else if (exp_rdy && in_valid) begin
        m_busy  = 1'b1;
        m_beat  = 0;
        m_dec   = ref_decode(h[9:8], h[7], h[6:3]);
        m_beats = m_dec[0] ? int'(BEATS) : 1;
      end else if (m_busy && out_ready && m_last) begin
        m_busy = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cu_seq_decoder.md
Name: cu_seq_decoder

Overview:
Registered, multi-beat successor to the combinational control unit, sitting between the fetch/decode register and the decode/execute stage.
- Decodes the 10-bit instruction header into the deco_exe control bundle plus RegSrcA1, RegSrcA2 and bLink.
- Fully defines immediate-mode decode, memory and branch classes, and a new vector class.
- Vector instructions are sequenced over VLEN/LANES beats with a valid/ready handshake on both sides.

Parameters:
- VLEN, 16, elements per vector register; must be a multiple of LANES.
- LANES, 4, elements processed per beat; 1 <= LANES <= VLEN.
- HEADER_W, 10, instruction header width (fixed layout, see package).
- Derived: BEATS = VLEN/LANES; BW = max(1, $clog2(BEATS)).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  header available.
- in_ready  out  1  block can accept a header this cycle.
- inst_head  in  HEADER_W  header: op[9:8], immSignal[7], cmd[6:3], rsvd[2:0].
- flush  in  1  discard current instruction (branch taken downstream).
- out_valid  out  1  ctr_signal valid for the current beat.
- out_ready  in  1  execute stage accepts the beat.
- ctr_signal  out  CTRL_W  {RegWrite, ALUSrc, ALUCtrl[2:0], FlagsWrite, MemWrite, MemToReg, Branch, VecMode}.
- RegSrcA1  out  1  register-file port A1 reads PC (branches).
- RegSrcA2  out  1  register-file port A2 reads Rd (STR).
- bLink  out  1  write link register (BL).
- beat_idx  out  BW  index of the current beat, 0..BEATS-1.
- last_beat  out  1  current beat is the final beat of the instruction.
- illegal  out  1  undefined encoding; a NOP bundle is emitted.

Behaviour:
- Reset: state IDLE. All outputs 0, including in_ready. in_ready rises the first cycle after rst deasserts.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - ISSUE: out_valid=1, outputs held stable until out_ready.
- IDLE->ISSUE on in_valid & in_ready. The header is decoded and registered, so out_valid appears 1 cycle after acceptance; beat_idx=0.
- ISSUE, beat handshake (out_valid & out_ready):
  - Not last beat: beat_idx+1, bundle unchanged.
  - Last beat: in_ready=1 combinationally in that cycle. If in_valid, load the next header and stay in ISSUE (back-to-back, no bubble); otherwise go to IDLE.
- ISSUE without handshake: all outputs hold (backpressure). in_ready=0, except on the last beat as above.
- Beat count:
  - Scalar classes (op 00, 01, 10): one beat.
  - Vector class (op 11): BEATS beats, VecMode=1.
  - When BEATS==1, a vector instruction is single-beat; beat_idx is always 0.
  - last_beat = (beat_idx == beats_of_current-1) & out_valid.
- PROCESSING (op 00) and VECTOR (op 11), cmd:
  - NOP 0: all 0.
  - AND 1: RegWrite, ALUCtrl=010.
  - XOR 2: RegWrite, ALUCtrl=011.
  - SUB 3: RegWrite, ALUCtrl=001.
  - ADD 4: RegWrite, ALUCtrl=000.
  - CMP 5: FlagsWrite, ALUCtrl=001, RegWrite=0.
  - ALUSrc = immSignal for every cmd.
- MEMORY (op 01), cmd:
  - LDR 0: RegWrite, MemToReg, ALUSrc=1, ALUCtrl=000.
  - STR 1: MemWrite, ALUSrc=1, ALUCtrl=000, RegSrcA2=1.
- BRANCH (op 10), cmd:
  - B 0: Branch, RegSrcA1, ALUSrc=1, ALUCtrl=000.
  - BL 1: as B, plus bLink=1 and RegWrite=1.
- Undefined cmd in any class: single-beat NOP bundle with illegal=1, asserted for that beat only. rsvd bits are ignored.
- flush: takes priority over everything except rst.
  - Next cycle: out_valid=0, state IDLE, beat_idx=0, illegal=0.
  - A header offered in the flush cycle is not accepted (in_ready forced 0 that cycle).
- Simultaneous last-beat handshake and flush: flush wins; the next header is not accepted.
- rst mid-vector: abandons remaining beats; same state as power-up reset.

Decomposition:
- Package cu_definitions_pkg (extend the existing one) holds:
  - Header fields and inst_header struct.
  - Op codes PROCESSING/MEMORY/BRANCH/VECTOR and cmd enums.
  - ALUCtrl constants, CTRL_W, and the ctrl bundle struct.
  - A function decode_header(inst_header) returning {bundle, RegSrcA1, RegSrcA2, bLink, illegal, is_vector}.
- Optional sub-module cu_beat_counter (BW-bit counter with load, inc, terminal compare) used by the FSM.

Test Plan:
1. rst held 3 cycles, then released -> all outputs 0 during reset; in_ready=1 on the first cycle after release.
2. PROCESSING ADD reg (op00, imm0, cmd4), out_ready=1 -> next cycle out_valid=1, RegWrite=1, ALUSrc=0, ALUCtrl=000, last_beat=1. Repeat with imm1 -> ALUSrc=1.
3. BL (op10, cmd1) -> Branch=1, RegSrcA1=1, bLink=1, RegWrite=1. CMP (op00, cmd5) -> FlagsWrite=1, RegWrite=0, ALUCtrl=001.
4. Vector ADD, VLEN=16, LANES=4, out_ready=1, back-to-back STR queued -> beat_idx 0,1,2,3, in_ready=0 on beats 0-2, last_beat on beat 3. STR issues the next cycle with no bubble, RegSrcA2=1, MemWrite=1.
5. Vector SUB with out_ready low for 3 cycles at beat 1 -> beat_idx, ctr_signal and out_valid stable; resumes at beat 2 after out_ready returns.
6. flush at beat 2 of a vector op, then cmd=9 (op00) -> out_valid=0 next cycle, state IDLE. Next header yields a NOP bundle with illegal=1 for one beat.
